// File: rtl/imem_loader_if.sv
// Byte-stream handshake and imem port A write bus for imem_loader.
// master = loader side (drives in_ready and the imem write bus), slave = host/memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_en;
  logic [3:0]        imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_en, imem_we, imem_addr, imem_din
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_en, imem_we, imem_addr, imem_din
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> little-endian words -> imem port A, core held in reset until loaded.
// Optional trailing XOR checksum stage compiled in with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  imem_loader_if.master bus,
  output logic          cpu_reset_o,
  output logic          done_o,
  output logic          error_o
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_FLUSH;
`endif

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       buf_q, buf_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              in_ready;
  logic              fire;
  logic [15:0]       hdr_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_HDR0;
      count_q <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                 in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign fire      = bus.in_valid && in_ready;
  assign hdr_count = {bus.in_data, count_q[7:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (fire && state_q != S_CSUM) csum_d = csum_q ^ bus.in_data;
`endif
    case (state_q)
      S_HDR0: begin
        if (fire) begin
          count_d[7:0] = bus.in_data;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (fire) begin
          count_d = hdr_count;
          word_d  = '0;
          lane_d  = '0;
          // Over-length images are rejected here, so the word address never wraps.
          if ({1'b0, hdr_count} > MAX_WORDS) state_d = S_ERR;
          else if (hdr_count == 16'd0)       state_d = S_TAIL;
          else                               state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: buf_d[7:0]   = bus.in_data;
            2'd1: buf_d[15:8]  = bus.in_data;
            2'd2: buf_d[23:16] = bus.in_data;
            default: begin
              en_d   = 1'b1;
              addr_d = word_q[ADDR_W-1:0];
              din_d  = {bus.in_data, buf_q};
              word_d = word_q + 16'd1;
              if (word_q + 16'd1 == count_q) state_d = S_TAIL;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (fire) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.imem_en   = en_q;
  assign bus.imem_we   = en_q ? 4'hF : 4'h0;
  assign bus.imem_addr = addr_q;
  assign bus.imem_din  = din_q;

  assign cpu_reset_o = (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign error_o     = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected imem writes go through a scoreboard queue.
// Works in both builds (IMEM_LOADER_CHECKSUM_EN defined or not).
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic cpu_reset, done, error;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .bus        (bus),
    .cpu_reset_o(cpu_reset),
    .done_o     (done),
    .error_o    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  tb_csum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus.imem_en === 1'b1) begin
      chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e[39:32]));
        chk("wr_din", bus.imem_din, e[31:0]);
        chk("wr_we", 32'(bus.imem_we), 32'h0000000F);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; leaves off at the negedge after the handshake edge.
  task automatic put(input logic [7:0] b, input bit gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tb_csum      = tb_csum ^ b;
    @(posedge clk);
    @(negedge clk);
    if (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hE7;
      @(negedge clk);
    end
  endtask

  task automatic push_word(input logic [7:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
  endtask

  task automatic put_word(input logic [31:0] w, input bit gap);
    put(w[7:0], gap);
    put(w[15:8], gap);
    put(w[23:16], gap);
    put(w[31:24], gap);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tb_csum      = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Ends a good load after its last data byte and checks the core is released.
  task automatic finish_ok(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = tb_csum;
    put(c, 1'b0);
    bus.in_valid = 1'b0;
`else
    bus.in_valid = 1'b0;
    chk({tag, "_flush_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_flush_done"}, 32'(done), 32'd0);
    chk({tag, "_flush_cpurst"}, 32'(cpu_reset), 32'd1);
    @(negedge clk);
`endif
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tb_csum      = 8'h00;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_en", 32'(bus.imem_en), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_din", bus.imem_din, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single word, valid held high.
    put(8'h01, 1'b0);
    put(8'h00, 1'b0);
    push_word(8'd0, 32'h00A00513);
    put_word(32'h00A00513, 1'b0);
    chk("t1_pulse_cycle", 32'(bus.imem_en), 32'd1);
    finish_ok("t1");
    do_reset();

    // Three words with idle cycles between bytes.
    put(8'h03, 1'b1);
    put(8'h00, 1'b1);
    push_word(8'd0, 32'h44332211);
    push_word(8'd1, 32'h88776655);
    push_word(8'd2, 32'hCCBBAA99);
    put_word(32'h44332211, 1'b1);
    put_word(32'h88776655, 1'b1);
    put(8'h99, 1'b1);
    put(8'hAA, 1'b1);
    put(8'hBB, 1'b1);
    put(8'hCC, 1'b0);
    finish_ok("t2");
    do_reset();

    // Count 257 exceeds the 256-word imem.
    put(8'h01, 1'b0);
    put(8'h01, 1'b0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_cpurst", 32'(cpu_reset), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t3_error_sticky", 32'(error), 32'd1);
    do_reset();

    // Empty image.
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    finish_ok("t4");
    do_reset();

    // Largest legal image: 256 words, last address 255.
    put(8'h00, 1'b0);
    put(8'h01, 1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0]  a;
      logic [31:0] w;
      a = 8'(i);
      w = {8'hC3, ~a, a ^ 8'h5A, a};
      push_word(a, w);
      put_word(w, 1'b0);
    end
    finish_ok("t5");
    do_reset();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: write still happens, core stays in reset.
    put(8'h01, 1'b0);
    put(8'h00, 1'b0);
    push_word(8'd0, 32'h00A00513);
    put_word(32'h00A00513, 1'b0);
    chk("t6_csum_model", 32'(tb_csum), 32'h000000B7);
    put(8'hB6, 1'b0);
    bus.in_valid = 1'b0;
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_cpurst", 32'(cpu_reset), 32'd1);
    chk("t6_write_seen", 32'(exp_q.size()), 32'd0);
    do_reset();
`endif

    // Asynchronous reset in the middle of a two-word load.
    put(8'h02, 1'b0);
    put(8'h00, 1'b0);
    push_word(8'd0, 32'h40302010);
    put_word(32'h40302010, 1'b0);
    put(8'h50, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t7_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t7_en", 32'(bus.imem_en), 32'd0);
    chk("t7_we", 32'(bus.imem_we), 32'd0);
    chk("t7_addr", 32'(bus.imem_addr), 32'd0);
    chk("t7_din", bus.imem_din, 32'd0);
    chk("t7_cpurst", 32'(cpu_reset), 32'd1);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_error", 32'(error), 32'd0);
    bus.in_valid = 1'b0;
    tb_csum      = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    put(8'h01, 1'b0);
    put(8'h00, 1'b0);
    push_word(8'd0, 32'hEFBEADDE);
    put_word(32'hEFBEADDE, 1'b0);
    finish_ok("t7");
    @(negedge clk);
    chk("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
